// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: single-ported memory shared by instruction fetch and data
// access; data has priority, with fetch starvation bounded by STARVE_MAX.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_kill,
  output logic          i_ack,
  output logic [31:0]   i_rdata,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

  state_t     state;
  state_t     state_next;
  logic [3:0] streak;
  logic       kill_pend;
  logic       i_elig;
  logic       d_elig;
  logic       i_grant;
  logic       d_grant;
  logic       i_done;
  logic       d_done;

  // A port in its ack cycle is not eligible, so it cannot be re-granted at once.
  assign i_elig  = i_req & ~i_ack;
  assign d_elig  = d_req & ~d_ack;
  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;
  assign mem_req = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    i_grant    = 1'b0;
    d_grant    = 1'b0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    case (state)
      IDLE: begin
        if (d_elig && (!i_elig || (streak < STREAK_MAX))) begin
          d_grant    = 1'b1;
          state_next = DBUSY;
        end else if (i_elig) begin
          i_grant    = 1'b1;
          state_next = IBUSY;
        end
      end
      IBUSY: begin
        if (mem_ready) begin
          i_done     = 1'b1;
          state_next = IDLE;
        end
      end
      DBUSY: begin
        if (mem_ready) begin
          d_done     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak    <= '0;
      kill_pend <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;

      if (d_grant) begin
        mem_addr  <= d_addr;
        mem_we    <= d_we;
        mem_wdata <= d_wdata;
        if (i_elig) begin
          streak <= (streak < STREAK_MAX) ? streak + 4'd1 : STREAK_MAX;
        end else begin
          streak <= '0;
        end
      end

      if (i_grant) begin
        mem_addr  <= i_addr;
        mem_we    <= 1'b0;
        kill_pend <= i_kill;
        streak    <= '0;
      end

      // A squash arriving in the completion cycle still suppresses the ack.
      if (state == IBUSY) begin
        if (i_done) begin
          kill_pend <= 1'b0;
          if (!(kill_pend | i_kill)) begin
            i_ack   <= 1'b1;
            i_rdata <= mem_rdata[31:0];
          end
        end else if (i_kill) begin
          kill_pend <= 1'b1;
        end
      end

      if (d_done) begin
        d_ack <= 1'b1;
        if (!mem_we) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter: directed scenarios plus randomized traffic compared
// every cycle against an ownership-based reference model.
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_kill, i_ack, i_stall;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_rdata;
  logic          d_req, d_we, d_ack, d_stall;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_ack(i_ack),
    .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory emulation ----------------
  logic [63:0] store [logic [63:0]];
  int busy_cnt      = 0;
  int target        = 0;
  int mem_delay_cfg = -1;
  bit stray_ready   = 1'b0;

  function automatic logic [63:0] rd(input logic [63:0] a);
    if (store.exists(a)) return store[a];
    return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
  endfunction

  task automatic mem_drive();
    mem_ready = 1'b0;
    mem_rdata = {$urandom, $urandom};
    if (mem_req) begin
      if (busy_cnt == 0)
        target = (mem_delay_cfg < 0) ? int'($urandom_range(0, 3)) : mem_delay_cfg;
      if (busy_cnt >= target) begin
        mem_ready = 1'b1;
        if (mem_we) store[mem_addr] = mem_wdata;
        else        mem_rdata = rd(mem_addr);
        busy_cnt = 0;
      end else begin
        busy_cnt++;
      end
    end else begin
      busy_cnt = 0;
      if (stray_ready) begin
        mem_ready   = 1'b1;
        stray_ready = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_drive();
  endtask

  // ---------------- reference model ----------------
  // owner: 0 = memory free, 1 = fetch owns it, 2 = data owns it
  int            m_owner;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  logic          m_iack, m_dack;
  logic [31:0]   m_irdata;
  logic [DW-1:0] m_drdata;
  int            m_streak;
  bit            m_kill;

  always @(posedge clk or posedge rst) begin : model_step
    bit ie, de, ack_i, ack_d;
    if (rst) begin
      m_owner = 0; m_addr = '0; m_we = 1'b0; m_wdata = '0;
      m_iack = 1'b0; m_dack = 1'b0; m_irdata = '0; m_drdata = '0;
      m_streak = 0; m_kill = 1'b0;
    end else begin
      ie = i_req && !m_iack;
      de = d_req && !m_dack;
      ack_i = 1'b0;
      ack_d = 1'b0;
      if (m_owner == 0) begin
        if (de && (!ie || m_streak < SMAX)) begin
          m_owner = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
          m_streak = ie ? ((m_streak + 1 > SMAX) ? SMAX : m_streak + 1) : 0;
        end else if (ie) begin
          m_owner = 1; m_addr = i_addr; m_we = 1'b0; m_kill = i_kill; m_streak = 0;
        end
      end else if (m_owner == 1) begin
        if (i_kill) m_kill = 1'b1;
        if (mem_ready) begin
          if (!m_kill) begin
            ack_i    = 1'b1;
            m_irdata = mem_rdata[31:0];
          end
          m_kill  = 1'b0;
          m_owner = 0;
        end
      end else begin
        if (mem_ready) begin
          ack_d = 1'b1;
          if (!m_we) m_drdata = mem_rdata;
          m_owner = 0;
        end
      end
      m_iack = ack_i;
      m_dack = ack_d;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("mem_req",   64'(mem_req),   64'(m_owner != 0));
      chk("mem_addr",  mem_addr,       m_addr);
      chk("mem_we",    64'(mem_we),    64'(m_we));
      chk("mem_wdata", mem_wdata,      m_wdata);
      chk("i_ack",     64'(i_ack),     64'(m_iack));
      chk("d_ack",     64'(d_ack),     64'(m_dack));
      chk("i_rdata",   64'(i_rdata),   64'(m_irdata));
      chk("d_rdata",   d_rdata,        m_drdata);
      chk("i_stall",   64'(i_stall),   64'(i_req & ~m_iack));
      chk("d_stall",   64'(d_stall),   64'(d_req & ~m_dack));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] rand_addr();
    return 64'($urandom_range(0, 31)) << 3;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit          ok, seen, prev_req;
    int          n, ng;
    logic [15:0] pat;
    logic [31:0] prev_ird;

    rst = 1'b1; i_req = 1'b0; i_addr = '0; i_kill = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    store[64'h40] = 64'h0000_0000_00A0_0093;
    store[64'h80] = 64'hDEAD_BEEF_0010_0073;
    store[64'h08] = 64'h1111_2222_3333_4444;
    store[64'h10] = 64'h5555_6666_7777_8888;

    repeat (3) @(posedge clk);
    #4;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_acks", 64'({i_ack, d_ack, mem_we}), 64'd0);
    chk("rst_rdata", d_rdata | 64'(i_rdata), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Idle then fetch
    mem_delay_cfg = 2;
    i_addr = 64'h40; i_req = 1'b1;
    ok = 1'b0; seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (mem_req && !seen) begin
        seen = 1'b1;
        chk("t1_mem_addr", mem_addr, 64'h40);
        chk("t1_mem_we", 64'(mem_we), 64'd0);
      end
      if (i_ack) begin ok = 1'b1; break; end
    end
    chk("t1_ack_seen", 64'(ok), 64'd1);
    chk("t1_i_rdata", 64'(i_rdata), 64'h00A0_0093);
    chk("t1_i_stall", 64'(i_stall), 64'd0);
    i_req = 1'b0;
    tick();

    // Simultaneous requests: data first, fetch right after d_ack
    mem_delay_cfg = 1;
    i_addr = 64'h300; i_req = 1'b1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'h1234;
    tick();
    tick();
    chk("t2_mem_we", 64'(mem_we), 64'd1);
    chk("t2_mem_wdata", mem_wdata, 64'h1234);
    chk("t2_mem_addr", mem_addr, 64'h100);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (d_ack) begin ok = 1'b1; break; end
      tick();
    end
    chk("t2_dack_seen", 64'(ok), 64'd1);
    d_req = 1'b0;
    tick();
    chk("t2_fetch_req", 64'(mem_req), 64'd1);
    chk("t2_fetch_addr", mem_addr, 64'h300);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (i_ack) begin ok = 1'b1; break; end
    end
    chk("t2_iack_seen", 64'(ok), 64'd1);
    i_req = 1'b0;
    tick();

    // Starvation bound: fetch waits at every data grant decision
    mem_delay_cfg = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h1000;
    i_addr = 64'h200; i_req = 1'b1;
    ng = 0; pat = '0; prev_req = 1'b0;
    for (int k = 0; k < 200 && ng < 11; k++) begin
      tick();
      if (mem_req && !prev_req) begin
        if (ng < 16) pat[ng] = (mem_addr == 64'h200);
        ng++;
      end
      prev_req = mem_req;
      i_req = !d_ack;
    end
    chk("t3_grant_count", 64'(ng), 64'd11);
    chk("t3_grant_seq", 64'(pat), 64'h0410);
    d_req = 1'b0; i_req = 1'b0;
    repeat (8) tick();

    // Kill an outstanding fetch, redirect to 0x80
    mem_delay_cfg = 3;
    i_addr = 64'h60; i_req = 1'b1;
    tick();
    tick();
    chk("t4_busy", 64'(mem_req), 64'd1);
    prev_ird = i_rdata;
    i_kill = 1'b1; i_addr = 64'h80;
    tick();
    i_kill = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!mem_req) begin ok = 1'b1; break; end
    end
    chk("t4_idle_seen", 64'(ok), 64'd1);
    chk("t4_no_ack", 64'(i_ack), 64'd0);
    chk("t4_rdata_held", 64'(i_rdata), 64'(prev_ird));
    ok = 1'b0; seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (mem_req && !seen) begin
        seen = 1'b1;
        chk("t4_refetch_addr", mem_addr, 64'h80);
      end
      if (i_ack) begin ok = 1'b1; break; end
    end
    chk("t4_iack_seen", 64'(ok), 64'd1);
    chk("t4_i_rdata", 64'(i_rdata), 64'h0010_0073);
    i_req = 1'b0;
    tick();

    // Asynchronous reset while data owns the memory
    mem_delay_cfg = 6;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h200;
    tick();
    tick();
    chk("t5_busy", 64'(mem_req), 64'd1);
    #3;
    rst = 1'b1; chk_en = 1'b0;
    #1;
    chk("t5_mem_req", 64'(mem_req), 64'd0);
    chk("t5_mem_addr", mem_addr, 64'd0);
    chk("t5_mem_wdata", mem_wdata, 64'd0);
    chk("t5_flags", 64'({mem_we, i_ack, d_ack}), 64'd0);
    chk("t5_rdata", d_rdata | 64'(i_rdata), 64'd0);
    d_req = 1'b0; busy_cnt = 0;
    @(posedge clk);
    #4;
    rst = 1'b0; chk_en = 1'b1;
    stray_ready = 1'b1;
    tick();
    tick();
    chk("t5_stray_dack", 64'(d_ack), 64'd0);
    chk("t5_stray_iack", 64'(i_ack), 64'd0);
    chk("t5_stray_req", 64'(mem_req), 64'd0);

    // Back-to-back data reads
    mem_delay_cfg = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h08;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (d_ack) begin ok = 1'b1; break; end
    end
    chk("t6_ack1_seen", 64'(ok), 64'd1);
    chk("t6_rdata1", d_rdata, 64'h1111_2222_3333_4444);
    d_addr = 64'h10;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n++;
      if (d_ack) break;
    end
    chk("t6_ack_spacing", 64'(n), 64'd3);
    chk("t6_rdata2", d_rdata, 64'h5555_6666_7777_8888);
    d_req = 1'b0;
    tick();

    // Randomized traffic: protocol-compliant, then free-running requests
    mem_delay_cfg = -1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c < 1500) begin
        if (i_req && i_ack) begin
          i_req = 1'($urandom_range(0, 1));
          i_addr = rand_addr();
        end else if (!i_req && $urandom_range(0, 2) == 0) begin
          i_req = 1'b1;
          i_addr = rand_addr();
        end
        if (d_req && d_ack) begin
          d_req = 1'($urandom_range(0, 1));
          d_we = 1'($urandom_range(0, 1));
          d_addr = rand_addr(); d_wdata = {$urandom, $urandom};
        end else if (!d_req && $urandom_range(0, 1) == 0) begin
          d_req = 1'b1;
          d_we = 1'($urandom_range(0, 1));
          d_addr = rand_addr(); d_wdata = {$urandom, $urandom};
        end
      end else begin
        i_req = 1'($urandom_range(0, 1));
        d_req = ($urandom_range(0, 3) != 0);
        d_we = 1'($urandom_range(0, 1));
        i_addr = rand_addr(); d_addr = rand_addr(); d_wdata = {$urandom, $urandom};
      end
      i_kill = 1'b0;
      if (i_req && !mem_ready && $urandom_range(0, 9) == 0) begin
        i_kill = 1'b1;
        i_addr = rand_addr();
      end
    end
    i_req = 1'b0; d_req = 1'b0; i_kill = 1'b0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
